// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_if
// Description : Single-outstanding request/grant/response data-bus bundle
//               between the memory stage and the data memory.
//               master : stage side (drives req/we/addr/wdata/be)
//               slave  : memory side (drives gnt/rvalid/rdata)
// Ports       : dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
//               dmem_gnt, dmem_rvalid, dmem_rdata
// Revision    : 1.0  initial release
// ============================================================================
interface mem_access_stage_if #(
    parameter int SIZE = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [SIZE-1:0] dmem_addr;
    logic [SIZE-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [SIZE-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the 5-stage RV32I pipeline. Issues loads and
//               stores on a single-outstanding data bus, builds byte-lane
//               stores, sizes/sign-extends load data, flags misaligned
//               accesses and stalls the front of the pipe while an access is
//               in flight. Produces the WB-bound pipeline registers.
// Ports       : clk, reset (sync, active-low)
//               control_registers_MEM, ALU_result, rs2_store_data_MEM, PC_MEM
//               bus (mem_access_stage_if.master)
//               misaligned_ldst_exception, mem_stall
//               control_registers_WB, ALU_result_to_WB
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_stage #(
    parameter int SIZE = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [13:0]      control_registers_MEM,
    input  wire logic [SIZE-1:0]  ALU_result,
    input  wire logic [SIZE-1:0]  rs2_store_data_MEM,
    input  wire logic [SIZE-1:0]  PC_MEM,
    mem_access_stage_if.master    bus,
    output logic                  misaligned_ldst_exception,
    output logic                  mem_stall,
    output logic [9:0]            control_registers_WB,
    output logic [SIZE-1:0]       ALU_result_to_WB
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    logic            w_ld;
    logic            w_st;
    logic [2:0]      w_f3;
    logic            w_misaligned;
    logic            w_req;
    logic            w_load_done;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [SIZE-1:0] w_load_data;
    logic [SIZE-1:0] w_wdata;
    logic [3:0]      w_be;
    logic            w_unused;

    assign w_ld = control_registers_MEM[1] & ~control_registers_MEM[2];
    assign w_st = control_registers_MEM[2];
    assign w_f3 = control_registers_MEM[12:10];

    // PC_MEM is consumed by the CSR logic alongside the exception flag;
    // jump_r/branch/jump are not needed past EXE.
    assign w_unused = ^{PC_MEM, control_registers_MEM[13],
                        control_registers_MEM[4], control_registers_MEM[0]};

    assign w_misaligned = ((w_f3[1:0] == 2'd1) && ALU_result[0]) ||
                          ((w_f3[1:0] == 2'd2) && (ALU_result[1:0] != 2'b00));

    // Only meaningful while no access is in flight: in WAIT_R the op in MEM
    // is the already-validated load.
    assign misaligned_ldst_exception = (w_ld | w_st) & w_misaligned &
                                       (r_state == IDLE);

    // ------------------------------------------------------------------
    // Bus control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        mem_stall   = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_ld | w_st) && !w_misaligned) begin
                    w_req = 1'b1;
                    if (w_st) begin
                        // A granted store completes in the request cycle.
                        mem_stall = ~bus.dmem_gnt;
                    end else begin
                        mem_stall = 1'b1;
                        if (bus.dmem_gnt) begin
                            w_next = WAIT_R;
                        end
                    end
                end
            end
            WAIT_R: begin
                if (bus.dmem_rvalid) begin
                    w_load_done = 1'b1;
                    w_next      = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane generation
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_store_data_MEM;
        case (w_f3[1:0])
            2'd0: begin
                w_be    = 4'b0001 << ALU_result[1:0];
                w_wdata = {(SIZE/8){rs2_store_data_MEM[7:0]}};
            end
            2'd1: begin
                w_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(SIZE/16){rs2_store_data_MEM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = rs2_store_data_MEM;
            end
        endcase
    end

    assign bus.dmem_req   = w_req;
    assign bus.dmem_we    = w_st;
    assign bus.dmem_addr  = {ALU_result[SIZE-1:2], 2'b00};
    assign bus.dmem_be    = w_be;
    assign bus.dmem_wdata = w_wdata;

    // ------------------------------------------------------------------
    // Load data extraction
    // ------------------------------------------------------------------
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_load_data = '0;
        case (ALU_result[1:0])
            2'd0:    w_byte = bus.dmem_rdata[7:0];
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            default: w_byte = bus.dmem_rdata[31:24];
        endcase
        w_half = ALU_result[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (w_f3)
            3'd0:    w_load_data = {{(SIZE-8){w_byte[7]}}, w_byte};
            3'd4:    w_load_data = {{(SIZE-8){1'b0}}, w_byte};
            3'd1:    w_load_data = {{(SIZE-16){w_half[15]}}, w_half};
            3'd5:    w_load_data = {{(SIZE-16){1'b0}}, w_half};
            3'd2:    w_load_data = bus.dmem_rdata;
            default: w_load_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // WB pipeline registers. Stalled cycles and faulting ops write a bubble
    // so nothing is retired twice and EXE never forwards a stale value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            control_registers_WB <= '0;
            ALU_result_to_WB     <= '0;
        end else if (mem_stall || misaligned_ldst_exception) begin
            control_registers_WB <= '0;
            ALU_result_to_WB     <= '0;
        end else begin
            control_registers_WB <= {w_f3, control_registers_MEM[9:5],
                                     control_registers_MEM[3],
                                     control_registers_MEM[1]};
            ALU_result_to_WB     <= w_load_done ? w_load_data : ALU_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. A bus slave with
//               configurable grant/response latency drives the DUT; expected
//               results come from transaction-level reference functions.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic [13:0] ctrl;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic        exc;
    logic        mem_stall;
    logic [9:0]  wb_ctrl;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_pass   = 0;

    // observations filled by run_op
    int          o_stall, o_req, o_exc, o_bub;
    logic        o_unstable, o_seen, o_we;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;

    mem_access_stage_if #(.SIZE(32)) bus ();

    mem_access_stage #(.SIZE(32)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .control_registers_MEM     (ctrl),
        .ALU_result                (alu),
        .rs2_store_data_MEM        (rs2),
        .PC_MEM                    (pc),
        .bus                       (bus),
        .misaligned_ldst_exception (exc),
        .mem_stall                 (mem_stall),
        .control_registers_WB      (wb_ctrl),
        .ALU_result_to_WB          (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [13:0] mk_ctrl(input logic [2:0] f3, input logic [4:0] rd,
                                            input logic wr, input logic mw, input logic ld);
        mk_ctrl = {1'b0, f3, rd, 1'b0, wr, mw, ld, 1'b0};
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'd1) return (a % 2) != 0;
        if (f3[1:0] == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        v = 32'd0;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * (a % 4))) & 32'd255;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'd65535;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else if (f3 == 3'd2) begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [9:0] ref_wbctrl(input logic [13:0] c);
        return {c[12:10], c[9:5], c[3], c[1]};
    endfunction

    // ---------------- stimulus driver ----------------
    // Presents one op for its whole lifetime. gd = grant delay in cycles,
    // rdl = extra cycles between grant and rvalid. Irrelevant gnt/rvalid
    // cycles are randomised to exercise the ignore rules.
    task automatic run_op(input logic [13:0] c, input logic [31:0] a, input logic [31:0] d,
                          input int gd, input int rdl, input logic [31:0] rdat);
        logic is_ld, is_st, mem;
        int   n, rvk;
        is_ld = c[1] & ~c[2];
        is_st = c[2];
        mem   = (is_ld | is_st) && !ref_mis(c[12:10], a);
        rvk   = gd + 1 + rdl;
        n     = !mem ? 1 : (is_st ? gd + 1 : gd + rdl + 2);
        ctrl = c; alu = a; rs2 = d; pc = $urandom;
        o_stall = 0; o_req = 0; o_exc = 0; o_bub = 0;
        o_unstable = 1'b0; o_seen = 1'b0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.dmem_gnt = (mem && k <= gd) ? (k == gd) : 1'($urandom % 2);
            if (is_ld && mem && k > gd) bus.dmem_rvalid = (k == rvk);
            else                        bus.dmem_rvalid = 1'($urandom % 2);
            bus.dmem_rdata = (is_ld && mem && k == rvk) ? rdat : $urandom;
            @(negedge clk);
            if (mem_stall) o_stall++;
            if (exc)       o_exc++;
            if (bus.dmem_req) begin
                o_req++;
                if (!o_seen) begin
                    o_seen = 1'b1; o_addr = bus.dmem_addr; o_we = bus.dmem_we;
                    o_be = bus.dmem_be; o_wdata = bus.dmem_wdata;
                end else if (o_addr !== bus.dmem_addr || o_we !== bus.dmem_we ||
                             o_be !== bus.dmem_be || o_wdata !== bus.dmem_wdata) begin
                    o_unstable = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (k < n - 1 && (wb_ctrl !== 10'd0 || wb_data !== 32'd0)) o_bub++;
        end
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        ctrl = '0; alu = '0; rs2 = '0; pc = '0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_op(mk_ctrl(3'd0, 5'd3, 1'b1, 1'b0, 1'b0), 32'h5A5A_0001, 32'd0, 0, 0, 32'd0);
        reset = 1'b0;
        ctrl = mk_ctrl(3'd0, 5'd4, 1'b1, 1'b0, 1'b0); alu = 32'h7777_7777;
        @(posedge clk); #1;
        n_checks++;
        if (wb_ctrl !== 10'd0) $display("FAIL reset_wb_ctrl: got %h want 0", wb_ctrl);
        else n_pass++;
        n_checks++;
        if (wb_data !== 32'd0) $display("FAIL reset_wb_data: got %h want 0", wb_data);
        else n_pass++;
        reset = 1'b1; ctrl = '0; alu = '0;
    endtask

    task automatic test_alu_op();
        run_op(mk_ctrl(3'd0, 5'd5, 1'b1, 1'b0, 1'b0), 32'h0000_1234, 32'hFFFF_FFFF, 0, 0, 32'd0);
        n_checks++;
        if (wb_data !== 32'h1234) $display("FAIL alu_data: got %h want 00001234", wb_data);
        else n_pass++;
        n_checks++;
        if (wb_ctrl[6:2] !== 5'd5 || wb_ctrl[1] !== 1'b1)
            $display("FAIL alu_ctrl: got rd=%0d wr=%b want rd=5 wr=1", wb_ctrl[6:2], wb_ctrl[1]);
        else n_pass++;
        n_checks++;
        if (o_stall !== 0) $display("FAIL alu_stall: got %0d stall cycles want 0", o_stall);
        else n_pass++;
    endtask

    task automatic test_load_extract();
        run_op(mk_ctrl(3'd0, 5'd7, 1'b1, 1'b0, 1'b1), 32'h0000_0103, 32'd0, 0, 3, 32'h80FF_FF00);
        n_checks++;
        if (o_addr !== 32'h100) $display("FAIL lb_addr: got %h want 00000100", o_addr);
        else n_pass++;
        n_checks++;
        if (o_stall !== 4) $display("FAIL lb_stall: got %0d want 4", o_stall);
        else n_pass++;
        n_checks++;
        if (wb_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", wb_data);
        else n_pass++;
        run_op(mk_ctrl(3'd4, 5'd7, 1'b1, 1'b0, 1'b1), 32'h0000_0103, 32'd0, 0, 3, 32'h80FF_FF00);
        n_checks++;
        if (wb_data !== 32'h0000_0080) $display("FAIL lbu_data: got %h want 00000080", wb_data);
        else n_pass++;
    endtask

    task automatic test_store_lanes();
        logic [13:0] c;
        c = mk_ctrl(3'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        run_op(c, 32'h0000_0202, 32'hDEAD_BEEF, 2, 0, 32'd0);
        n_checks++;
        if (o_req !== 3 || o_unstable !== 1'b0)
            $display("FAIL sh_req: got %0d cycles unstable=%b want 3 stable", o_req, o_unstable);
        else n_pass++;
        n_checks++;
        if (o_be !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF || o_we !== 1'b1)
            $display("FAIL sh_lanes: got be=%b wdata=%h we=%b want 1100 beefbeef 1", o_be, o_wdata, o_we);
        else n_pass++;
        n_checks++;
        if (o_stall !== 2 || o_bub !== 0)
            $display("FAIL sh_stall: got stall=%0d nonbubble=%0d want 2 0", o_stall, o_bub);
        else n_pass++;
        n_checks++;
        if (wb_ctrl !== ref_wbctrl(c) || wb_data !== 32'h202)
            $display("FAIL sh_wb: got %h/%h want %h/00000202", wb_ctrl, wb_data, ref_wbctrl(c));
        else n_pass++;
    endtask

    task automatic test_misaligned();
        run_op(mk_ctrl(3'd2, 5'd6, 1'b1, 1'b0, 1'b1), 32'h0000_0006, 32'd0, 0, 0, 32'h1111_1111);
        n_checks++;
        if (o_exc !== 1 || o_req !== 0 || o_stall !== 0)
            $display("FAIL lw_mis: got exc=%0d req=%0d stall=%0d want 1 0 0", o_exc, o_req, o_stall);
        else n_pass++;
        n_checks++;
        if (wb_ctrl !== 10'd0 || wb_data !== 32'd0)
            $display("FAIL lw_mis_wb: got %h/%h want 0/0", wb_ctrl, wb_data);
        else n_pass++;
        run_op(mk_ctrl(3'd1, 5'd6, 1'b1, 1'b0, 1'b1), 32'h0000_0006, 32'd0, 1, 1, 32'h8001_2345);
        n_checks++;
        if (o_exc !== 0 || o_stall !== 3)
            $display("FAIL lh_ok: got exc=%0d stall=%0d want 0 3", o_exc, o_stall);
        else n_pass++;
        n_checks++;
        if (wb_data !== 32'hFFFF_8001) $display("FAIL lh_data: got %h want ffff8001", wb_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        ctrl = mk_ctrl(3'd2, 5'd9, 1'b1, 1'b0, 1'b1); alu = 32'h40; rs2 = '0;
        bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        bus.dmem_gnt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b1) $display("FAIL rstmid_wait: got stall=%b want 1", mem_stall);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; ctrl = '0; alu = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b0 || bus.dmem_req !== 1'b0)
            $display("FAIL rstmid_idle: got stall=%b req=%b want 0 0", mem_stall, bus.dmem_req);
        else n_pass++;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b0) $display("FAIL rstmid_late_stall: got %b want 0", mem_stall);
        else n_pass++;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
        n_checks++;
        if (wb_ctrl !== 10'd0 || wb_data !== 32'd0)
            $display("FAIL rstmid_late_wb: got %h/%h want 0/0", wb_ctrl, wb_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [13:0] cs, cl;
        logic [31:0] d;
        d  = $urandom;
        cs = mk_ctrl(3'd2, 5'd0, 1'b0, 1'b1, 1'b0);
        cl = mk_ctrl(3'd2, 5'd12, 1'b1, 1'b0, 1'b1);
        run_op(cs, 32'h0000_0880, d, 0, 0, 32'd0);
        n_checks++;
        if (o_stall !== 0 || wb_ctrl !== ref_wbctrl(cs))
            $display("FAIL b2b_sw: got stall=%0d wb=%h want 0 %h", o_stall, wb_ctrl, ref_wbctrl(cs));
        else n_pass++;
        run_op(cl, 32'h0000_0880, 32'd0, 0, 0, d);
        n_checks++;
        if (o_stall !== 1 || o_bub !== 0)
            $display("FAIL b2b_lw_stall: got stall=%0d nonbubble=%0d want 1 0", o_stall, o_bub);
        else n_pass++;
        n_checks++;
        if (wb_data !== d || wb_ctrl !== ref_wbctrl(cl))
            $display("FAIL b2b_lw_wb: got %h/%h want %h/%h", wb_ctrl, wb_data, ref_wbctrl(cl), d);
        else n_pass++;
    endtask

    task automatic test_random_mix();
        for (int it = 0; it < 60; it++) begin
            logic [13:0] c;
            logic [31:0] a, d, w, exp_d;
            logic [9:0]  exp_c;
            logic        ld, st, mis, mem;
            int          gd, rdl, kind, exp_stall;
            kind = $urandom % 4;
            c = 14'($urandom);
            if (kind == 0)      begin c[2] = 1'b0; c[1] = 1'b0; end
            else if (kind == 1) begin c[2] = 1'b0; c[1] = 1'b1; end
            else                begin c[2] = 1'b1; c[12:10] = 3'($urandom % 3); end
            a = $urandom; d = $urandom; w = $urandom;
            gd = $urandom % 4; rdl = $urandom % 4;
            ld = c[1] & ~c[2]; st = c[2];
            mis = (ld | st) && ref_mis(c[12:10], a);
            mem = (ld | st) && !mis;
            exp_stall = !mem ? 0 : (st ? gd : gd + rdl + 1);
            exp_c = mis ? 10'd0 : ref_wbctrl(c);
            exp_d = mis ? 32'd0 : (ld ? ref_load(c[12:10], a, w) : a);
            run_op(c, a, d, gd, rdl, w);
            n_checks++;
            if (o_stall !== exp_stall || o_bub !== 0)
                $display("FAIL rnd_stall[%0d]: got %0d/%0d want %0d/0", it, o_stall, o_bub, exp_stall);
            else n_pass++;
            n_checks++;
            if (o_req !== (mem ? gd + 1 : 0) || o_exc !== (mis ? 1 : 0) || o_unstable !== 1'b0)
                $display("FAIL rnd_req[%0d]: got req=%0d exc=%0d unst=%b want %0d %0d 0",
                         it, o_req, o_exc, o_unstable, mem ? gd + 1 : 0, mis ? 1 : 0);
            else n_pass++;
            if (mem) begin
                n_checks++;
                if (o_addr !== (a & 32'hFFFF_FFFC) || o_we !== st)
                    $display("FAIL rnd_addr[%0d]: got %h we=%b want %h %b", it, o_addr, o_we,
                             a & 32'hFFFF_FFFC, st);
                else n_pass++;
            end
            if (mem && st) begin
                n_checks++;
                if (o_be !== ref_be(c[12:10], a) || o_wdata !== ref_wdata(c[12:10], d))
                    $display("FAIL rnd_lanes[%0d]: got %b/%h want %b/%h", it, o_be, o_wdata,
                             ref_be(c[12:10], a), ref_wdata(c[12:10], d));
                else n_pass++;
            end
            n_checks++;
            if (wb_ctrl !== exp_c || wb_data !== exp_d)
                $display("FAIL rnd_wb[%0d]: got %h/%h want %h/%h", it, wb_ctrl, wb_data, exp_c, exp_d);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_extract();
        test_store_lanes();
        test_misaligned();
        test_reset_mid_access();
        test_back_to_back();
        test_random_mix();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
